ethernet_rx: RTL and testbench

RMII receive path of the Ethernet MAC: samples 2-bit RMII dibits, strips preamble/SFD, and extracts destination address, source address, length and payload. Payload bytes are pushed into the RX payload FIFO, and a descriptor (addresses, length, status) is pushed into the RX descriptor FIFO. FCS is checked with a local `ethernet_crc32` instance. Sits between the PHY RMII pins and the RX buffers, mirroring the TX path.

---
 rtl/ethernet_rx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ethernet_rx.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_rx.sv
// RMII receive deframer: strips preamble/SFD, captures header fields, pushes payload and a descriptor.
// Optional ETHERNET_RX_ADDR_FILTER_EN drops frames not addressed to MAC_ADDRESS or broadcast.

module ethernet_crc32 (
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    logic [31:0] c;

    // Reflected CRC-32 (poly 0xEDB88320), one byte per step, LSB first.
    always_comb begin
        c = crc_i ^ {24'd0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        crc_o = c;
    end
endmodule

module ethernet_rx #(
    parameter logic [5:0][7:0] MAC_ADDRESS = 48'h00_00_00_00_00_00
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            receive_i,
    input  logic [1:0]      rmii_rxd_i,
    input  logic            rmii_crs_dv_i,
    input  logic            data_full_i,
    output logic            write_data_o,
    output logic [7:0]      payload_data_o,
    output logic            write_descriptor_o,
    output logic [5:0][7:0] dest_address_o,
    output logic [5:0][7:0] src_address_o,
    output logic [15:0]     payload_length_o,
    output logic            crc_error_o,
    output logic            overflow_o,
    output logic            idle_o
);
    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        MAC_DESTINATION,
        MAC_SOURCE,
        ETH_TYPE,
        PAYLOAD,
        FRAME_CHECK_SEQUENCE,
        DROP
    } state_e;

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MAX_LENGTH  = 16'd1500;

    state_e          state_q, state_d;
    logic [5:0]      shift_q, shift_d;
    logic [1:0]      dibit_cnt_q, dibit_cnt_d;
    logic [10:0]     byte_cnt_q, byte_cnt_d;
    logic [31:0]     crc_q, crc_d, crc_next;
    logic [5:0][7:0] dest_q, dest_d;
    logic [5:0][7:0] src_q, src_d;
    logic [15:0]     length_q, length_d;
    logic            write_data_q, write_data_d;
    logic [7:0]      payload_q, payload_d;
    logic            write_desc_q, write_desc_d;
    logic            crc_error_q, crc_error_d;
    logic            overflow_q, overflow_d;
    logic            pushed_q, pushed_d;

    logic            in_frame;
    logic            byte_done;
    logic [7:0]      rx_byte;
    logic [2:0]      addr_idx;
    logic [15:0]     new_length;
    logic            addr_ok;

    // Only the three latest dibits are kept; the fourth completes the byte live.
    assign rx_byte    = {rmii_rxd_i, shift_q};
    assign in_frame   = state_q inside {MAC_DESTINATION, MAC_SOURCE, ETH_TYPE, PAYLOAD,
                                        FRAME_CHECK_SEQUENCE};
    assign byte_done  = in_frame && receive_i && rmii_crs_dv_i && (dibit_cnt_q == 2'd3);
    assign addr_idx   = 3'd5 - byte_cnt_q[2:0];
    assign new_length = {length_q[15:8], rx_byte};

`ifdef ETHERNET_RX_ADDR_FILTER_EN
    assign addr_ok = ({dest_q[5:1], rx_byte} == MAC_ADDRESS) ||
                     ({dest_q[5:1], rx_byte} == {6{8'hFF}});
`else
    logic unused_mac_address;
    assign unused_mac_address = ^MAC_ADDRESS;
    assign addr_ok = 1'b1;
`endif

    ethernet_crc32 u_crc (
        .crc_i  (crc_q),
        .data_i (rx_byte),
        .crc_o  (crc_next)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        dibit_cnt_d  = dibit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        crc_d        = crc_q;
        dest_d       = dest_q;
        src_d        = src_q;
        length_d     = length_q;
        write_data_d = 1'b0;
        payload_d    = payload_q;
        write_desc_d = 1'b0;
        crc_error_d  = crc_error_q;
        overflow_d   = overflow_q;
        pushed_d     = pushed_q;

        if (receive_i) begin
            shift_d = {rmii_rxd_i, shift_q[5:2]};
        end
        if (in_frame && receive_i && rmii_crs_dv_i) begin
            dibit_cnt_d = dibit_cnt_q + 2'd1;
        end
        if (byte_done) begin
            crc_d      = crc_next;
            byte_cnt_d = byte_cnt_q + 11'd1;
        end

        unique case (state_q)
            IDLE: begin
                dibit_cnt_d = '0;
                byte_cnt_d  = '0;
                crc_d       = '1;
                if (rmii_crs_dv_i && receive_i && (rmii_rxd_i == 2'b01)) begin
                    state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                dibit_cnt_d = '0;
                if (receive_i) begin
                    if (!rmii_crs_dv_i) begin
                        state_d = IDLE;
                    end else if (rmii_rxd_i == 2'b11) begin
                        state_d     = MAC_DESTINATION;
                        crc_error_d = 1'b0;
                        overflow_d  = 1'b0;
                        pushed_d    = 1'b0;
                    end else if (rmii_rxd_i != 2'b01) begin
                        state_d = DROP;
                    end
                end
            end
            MAC_DESTINATION: begin
                if (byte_done) begin
                    dest_d[addr_idx] = rx_byte;
                    if (byte_cnt_q == 11'd5) begin
                        byte_cnt_d = '0;
                        state_d    = addr_ok ? MAC_SOURCE : DROP;
                    end
                end
            end
            MAC_SOURCE: begin
                if (byte_done) begin
                    src_d[addr_idx] = rx_byte;
                    if (byte_cnt_q == 11'd5) begin
                        byte_cnt_d = '0;
                        state_d    = ETH_TYPE;
                    end
                end
            end
            ETH_TYPE: begin
                if (byte_done) begin
                    if (byte_cnt_q == 11'd0) begin
                        length_d[15:8] = rx_byte;
                    end else begin
                        length_d   = new_length;
                        byte_cnt_d = '0;
                        state_d    = ((new_length == 16'd0) || (new_length > MAX_LENGTH))
                                     ? DROP : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_done) begin
                    // A full FIFO loses the byte but the frame keeps going so the FCS still lines up.
                    if (data_full_i) begin
                        overflow_d = 1'b1;
                    end else begin
                        write_data_d = 1'b1;
                        payload_d    = rx_byte;
                        pushed_d     = 1'b1;
                    end
                    if (byte_cnt_q == (length_q[10:0] - 11'd1)) begin
                        byte_cnt_d = '0;
                        state_d    = FRAME_CHECK_SEQUENCE;
                    end
                end
            end
            FRAME_CHECK_SEQUENCE: begin
                if (byte_done && (byte_cnt_q == 11'd3)) begin
                    crc_error_d  = (crc_next != CRC_RESIDUE);
                    write_desc_d = 1'b1;
                    state_d      = DROP;
                end
            end
            DROP: begin
                if (receive_i && !rmii_crs_dv_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Carrier loss mid-frame: report a truncated frame only if software already saw its data.
        if (in_frame && receive_i && !rmii_crs_dv_i) begin
            state_d = IDLE;
            if (pushed_q) begin
                write_desc_d = 1'b1;
                crc_error_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            dibit_cnt_q  <= '0;
            byte_cnt_q   <= '0;
            crc_q        <= '1;
            dest_q       <= '0;
            src_q        <= '0;
            length_q     <= '0;
            write_data_q <= 1'b0;
            payload_q    <= '0;
            write_desc_q <= 1'b0;
            crc_error_q  <= 1'b0;
            overflow_q   <= 1'b0;
            pushed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            dibit_cnt_q  <= dibit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            crc_q        <= crc_d;
            dest_q       <= dest_d;
            src_q        <= src_d;
            length_q     <= length_d;
            write_data_q <= write_data_d;
            payload_q    <= payload_d;
            write_desc_q <= write_desc_d;
            crc_error_q  <= crc_error_d;
            overflow_q   <= overflow_d;
            pushed_q     <= pushed_d;
        end
    end

    assign write_data_o       = write_data_q;
    assign payload_data_o     = payload_q;
    assign write_descriptor_o = write_desc_q;
    assign dest_address_o     = dest_q;
    assign src_address_o      = src_q;
    assign payload_length_o   = length_q;
    assign crc_error_o        = crc_error_q;
    assign overflow_o         = overflow_q;
    assign idle_o             = (state_q == IDLE);
endmodule

// File: tb/tb_ethernet_rx.sv
// Randomized scoreboard bench for ethernet_rx: a frame-level model predicts pushes and descriptors,
// a monitor process compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_ethernet_rx;
    localparam logic [47:0] STATION   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BROADCAST = 48'hFF_FF_FF_FF_FF_FF;

    logic            clk_i         = 1'b0;
    logic            rst_n_i       = 1'b0;
    logic            receive_i     = 1'b0;
    logic [1:0]      rmii_rxd_i    = 2'b00;
    logic            rmii_crs_dv_i = 1'b0;
    logic            data_full_i   = 1'b0;
    logic            write_data_o;
    logic [7:0]      payload_data_o;
    logic            write_descriptor_o;
    logic [5:0][7:0] dest_address_o;
    logic [5:0][7:0] src_address_o;
    logic [15:0]     payload_length_o;
    logic            crc_error_o;
    logic            overflow_o;
    logic            idle_o;

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] len;
        logic        crc_err;
        logic        ovf;
    } desc_t;

    logic [7:0] exp_data_q[$];
    desc_t      exp_desc_q[$];
    logic [7:0] tx_bytes[$];
    bit         tx_full[$];
    logic [7:0] tx_payload[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mon_byte;
    desc_t      mon_desc;

    ethernet_rx #(.MAC_ADDRESS(STATION)) dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .receive_i          (receive_i),
        .rmii_rxd_i         (rmii_rxd_i),
        .rmii_crs_dv_i      (rmii_crs_dv_i),
        .data_full_i        (data_full_i),
        .write_data_o       (write_data_o),
        .payload_data_o     (payload_data_o),
        .write_descriptor_o (write_descriptor_o),
        .dest_address_o     (dest_address_o),
        .src_address_o      (src_address_o),
        .payload_length_o   (payload_length_o),
        .crc_error_o        (crc_error_o),
        .overflow_o         (overflow_o),
        .idle_o             (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Monitor: every push the DUT presents must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1) begin
            if (write_data_o === 1'b1) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_push: actual=%0h required=no push", payload_data_o);
                end else begin
                    mon_byte = exp_data_q.pop_front();
                    checkOutput("payload_byte", 64'(payload_data_o), 64'(mon_byte));
                end
            end
            if (write_descriptor_o === 1'b1) begin
                if (exp_desc_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_descriptor: actual=len %0h required=no descriptor",
                             payload_length_o);
                end else begin
                    mon_desc = exp_desc_q.pop_front();
                    checkOutput("desc_dst", 64'(dest_address_o), 64'(mon_desc.dst));
                    checkOutput("desc_src", 64'(src_address_o), 64'(mon_desc.src));
                    checkOutput("desc_len", 64'(payload_length_o), 64'(mon_desc.len));
                    checkOutput("desc_crc_error", 64'(crc_error_o), 64'(mon_desc.crc_err));
                    checkOutput("desc_overflow", 64'(overflow_o), 64'(mon_desc.ovf));
                end
            end
        end
    end

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, tx_bytes[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic fill_payload(input int n);
        tx_payload.delete();
        for (int i = 0; i < n; i++) tx_payload.push_back(8'($urandom));
    endtask

    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] len, input bit corrupt);
        logic [31:0] fcs;
        int          last;
        tx_bytes.delete();
        tx_full.delete();
        for (int i = 5; i >= 0; i--) tx_bytes.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) tx_bytes.push_back(src[8*i +: 8]);
        tx_bytes.push_back(len[15:8]);
        tx_bytes.push_back(len[7:0]);
        foreach (tx_payload[i]) tx_bytes.push_back(tx_payload[i]);
        fcs = fcs_of(tx_bytes.size());
        for (int i = 0; i < 4; i++) tx_bytes.push_back(fcs[8*i +: 8]);
        if (corrupt) begin
            last = tx_bytes.size() - 1;
            tx_bytes[last] = tx_bytes[last] ^ 8'h01;
        end
        foreach (tx_bytes[i]) tx_full.push_back(1'b0);
    endtask

    task automatic drive_dibit(input logic [1:0] d, input logic crs, input logic full);
        int gap;
        gap = ($urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0;
        for (int g = 0; g < gap; g++) begin
            receive_i   = 1'b0;
            rmii_rxd_i  = 2'($urandom);
            data_full_i = full;
            @(negedge clk_i);
        end
        receive_i     = 1'b1;
        rmii_rxd_i    = d;
        rmii_crs_dv_i = crs;
        data_full_i   = full;
        @(negedge clk_i);
        receive_i = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic crs, input logic full);
        for (int k = 0; k < 4; k++) drive_dibit(b[2*k +: 2], crs, full);
    endtask

    task automatic drive_preamble();
        for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b1, 1'b0);
        drive_byte(8'hD5, 1'b1, 1'b0);
    endtask

    task automatic finish_carrier();
        data_full_i = 1'b0;
        for (int i = 0; i < 3; i++) drive_dibit(2'b00, 1'b0, 1'b0);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic checkResetState();
        checkOutput("rst_write_data", 64'(write_data_o), 64'd0);
        checkOutput("rst_write_descriptor", 64'(write_descriptor_o), 64'd0);
        checkOutput("rst_crc_error", 64'(crc_error_o), 64'd0);
        checkOutput("rst_overflow", 64'(overflow_o), 64'd0);
        checkOutput("rst_dest", 64'(dest_address_o), 64'd0);
        checkOutput("rst_src", 64'(src_address_o), 64'd0);
        checkOutput("rst_length", 64'(payload_length_o), 64'd0);
        checkOutput("rst_idle", 64'(idle_o), 64'd1);
    endtask

    // Predict the frame's outcome from its bytes, then send the first 'cut' bytes and drop carrier.
    task automatic applyStimulus(input int cut);
        logic [47:0] dst, src;
        logic [15:0] len;
        logic [31:0] fcs_calc, fcs_rx;
        int          total, rx_payload, pushed;
        bit          ovf, accept;
        desc_t       d;
        total  = tx_bytes.size();
        dst    = {tx_bytes[0], tx_bytes[1], tx_bytes[2], tx_bytes[3], tx_bytes[4], tx_bytes[5]};
        src    = {tx_bytes[6], tx_bytes[7], tx_bytes[8], tx_bytes[9], tx_bytes[10], tx_bytes[11]};
        len    = {tx_bytes[12], tx_bytes[13]};
        accept = (len != 16'd0) && (len <= 16'd1500);
`ifdef ETHERNET_RX_ADDR_FILTER_EN
        if ((dst != STATION) && (dst != BROADCAST)) accept = 1'b0;
`endif
        if (accept) begin
            rx_payload = (cut > 14) ? cut - 14 : 0;
            if (rx_payload > int'(len)) rx_payload = int'(len);
            pushed = 0;
            ovf    = 1'b0;
            for (int i = 0; i < rx_payload; i++) begin
                if (tx_full[14+i]) begin
                    ovf = 1'b1;
                end else begin
                    exp_data_q.push_back(tx_bytes[14+i]);
                    pushed++;
                end
            end
            d.dst = dst;
            d.src = src;
            d.len = len;
            d.ovf = ovf;
            if (cut >= total) begin
                fcs_calc  = fcs_of(14 + int'(len));
                fcs_rx    = {tx_bytes[total-1], tx_bytes[total-2], tx_bytes[total-3], tx_bytes[total-4]};
                d.crc_err = (fcs_calc != fcs_rx);
                exp_desc_q.push_back(d);
            end else if (pushed > 0) begin
                d.crc_err = 1'b1;
                exp_desc_q.push_back(d);
            end
        end
        drive_preamble();
        checkOutput("idle_low_in_frame", 64'(idle_o), 64'd0);
        for (int i = 0; i < cut && i < total; i++) drive_byte(tx_bytes[i], 1'b1, tx_full[i]);
        finish_carrier();
        checkOutput("idle_after_frame", 64'(idle_o), 64'd1);
    endtask

    task automatic load_deadbeef();
        tx_payload.delete();
        tx_payload.push_back(8'hDE);
        tx_payload.push_back(8'hAD);
        tx_payload.push_back(8'hBE);
        tx_payload.push_back(8'hEF);
    endtask

    initial begin
        #900_000;
        checks++;
        failures++;
        $display("[TB] FAIL watchdog: actual=time %0t required=finish before limit", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [47:0] dst;
        logic [15:0] len;
        int          body, cut, sel;

        repeat (3) @(negedge clk_i);
        checkResetState();
        rst_n_i = 1'b1;
        @(negedge clk_i);

        $display("[TB] directed frames");
        load_deadbeef();
        build_frame(STATION, 48'h02_00_00_00_00_02, 16'h0004, 1'b0);
        applyStimulus(tx_bytes.size());

        build_frame(STATION, 48'h02_00_00_00_00_02, 16'h0004, 1'b1);
        applyStimulus(tx_bytes.size());

        build_frame(STATION, 48'h02_00_00_00_00_02, 16'h0800, 1'b0);
        applyStimulus(tx_bytes.size());

        build_frame(STATION, 48'h02_00_00_00_00_02, 16'h0004, 1'b0);
        tx_full[15] = 1'b1;
        applyStimulus(tx_bytes.size());

        build_frame(STATION, 48'h02_00_00_00_00_02, 16'h0004, 1'b0);
        applyStimulus(16);

        build_frame(48'h02_00_00_00_00_09, 48'h02_00_00_00_00_02, 16'h0004, 1'b0);
        applyStimulus(tx_bytes.size());
        build_frame(BROADCAST, 48'h02_00_00_00_00_02, 16'h0004, 1'b0);
        applyStimulus(tx_bytes.size());

        $display("[TB] length boundaries");
        tx_payload.delete();
        build_frame(STATION, 48'h02_00_00_00_00_03, 16'd0, 1'b0);
        applyStimulus(tx_bytes.size());
        fill_payload(1500);
        build_frame(STATION, 48'h02_00_00_00_00_03, 16'd1500, 1'b0);
        applyStimulus(tx_bytes.size());
        fill_payload(3);
        build_frame(STATION, 48'h02_00_00_00_00_03, 16'd1501, 1'b0);
        applyStimulus(tx_bytes.size());

        $display("[TB] random frames");
        for (int f = 0; f < 30; f++) begin
            sel = int'($urandom_range(3));
            dst = (sel == 0) ? STATION : (sel == 1) ? BROADCAST : {16'($urandom), 32'($urandom)};
            if ($urandom_range(5) == 0) begin
                len  = ($urandom_range(1) == 0) ? 16'd0 : 16'($urandom_range(65535, 1501));
                body = int'($urandom_range(6));
            end else begin
                len  = 16'($urandom_range(24, 1));
                body = int'(len);
            end
            fill_payload(body);
            build_frame(dst, {16'($urandom), 32'($urandom)}, len, ($urandom_range(3) == 0));
            for (int i = 14; i < 14 + body; i++) tx_full[i] = ($urandom_range(7) == 0);
            cut = ($urandom_range(4) == 0) ? int'($urandom_range(tx_bytes.size() - 1)) : tx_bytes.size();
            applyStimulus(cut);
        end

        $display("[TB] reset mid-payload");
        load_deadbeef();
        build_frame(STATION, 48'h02_00_00_00_00_02, 16'h0004, 1'b0);
        exp_data_q.push_back(tx_bytes[14]);
        exp_data_q.push_back(tx_bytes[15]);
        drive_preamble();
        for (int i = 0; i < 16; i++) drive_byte(tx_bytes[i], 1'b1, 1'b0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        checkResetState();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        finish_carrier();
        checkOutput("idle_after_reset", 64'(idle_o), 64'd1);

        for (int i = 0; i < 50 && (exp_data_q.size() != 0 || exp_desc_q.size() != 0); i++) begin
            @(negedge clk_i);
        end
        checkOutput("data_queue_drained", 64'(exp_data_q.size()), 64'd0);
        checkOutput("desc_queue_drained", 64'(exp_desc_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
